// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl_if
// Description : Register-write strobe bus and display outputs of the
//               two-digit seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_ctrl_if #(
    parameter int SEVEN_SEG_WIDTH = 7
);
    logic                       slv_reg_wren;
    logic [2:0]                 axi_awaddr;
    logic [31:0]                S_AXI_WDATA;
    logic [SEVEN_SEG_WIDTH-1:0] SEG;
    logic                       CAT;
    logic                       frame_tick;
    logic                       update_pending;

    modport master (
        output slv_reg_wren,
        output axi_awaddr,
        output S_AXI_WDATA,
        input  SEG,
        input  CAT,
        input  frame_tick,
        input  update_pending
    );

    modport slave (
        input  slv_reg_wren,
        input  axi_awaddr,
        input  S_AXI_WDATA,
        output SEG,
        output CAT,
        output frame_tick,
        output update_pending
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Two-digit multiplexed seven-segment scanner with blanking
//               gaps and frame-synchronous (tear-free) data update.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int SEVEN_SEG_WIDTH = 7,
    parameter int REFRESH_DIV     = 50000,
    parameter int BLANK_CYCLES    = 16
) (
    input  wire                    S_AXI_ACLK,
    input  wire                    S_AXI_ARESETN,
    seven_seg_scan_ctrl_if.slave   bus
);

    localparam int c_MAX_SLOT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_TIMER_W  = (c_MAX_SLOT > 1) ? $clog2(c_MAX_SLOT) : 1;
    localparam logic [c_TIMER_W-1:0] c_SHOW_LAST = c_TIMER_W'(REFRESH_DIV - 1);
    localparam logic [c_TIMER_W-1:0] c_GAP_LAST  = c_TIMER_W'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW0 = 3'd1,
        GAP0  = 3'd2,
        SHOW1 = 3'd3,
        GAP1  = 3'd4
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Assertion is immediate through the async clear; release takes two edges.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [7:0]                 r_shadow;
    logic [7:0]                 r_active;
    logic                       r_pending;
    logic                       r_enable;
    logic                       r_lzs;
    state_t                     r_state;
    logic [c_TIMER_W-1:0]       r_timer;
    logic [SEVEN_SEG_WIDTH-1:0] r_seg;
    logic                       r_cat;
    logic                       r_frame_tick;

    logic                       w_wr_data;
    logic                       w_wr_ctrl;
    logic                       w_boundary;
    logic [7:0]                 w_next_active;
    logic [SEVEN_SEG_WIDTH-1:0] w_seg0;
    logic [SEVEN_SEG_WIDTH-1:0] w_seg0_next;
    logic [SEVEN_SEG_WIDTH-1:0] w_seg1;
    logic                       w_unused_wdata;

    assign w_wr_data = bus.slv_reg_wren && (bus.axi_awaddr == 3'd0);
    assign w_wr_ctrl = bus.slv_reg_wren && (bus.axi_awaddr == 3'd1);

    assign w_boundary = r_enable &&
                        ((r_state == IDLE) || ((r_state == GAP1) && (r_timer == c_GAP_LAST)));

    assign w_next_active = r_pending ? r_shadow : r_active;

    assign w_seg0      = SEVEN_SEG_WIDTH'(hex_to_seg(r_active[3:0]));
    assign w_seg0_next = SEVEN_SEG_WIDTH'(hex_to_seg(w_next_active[3:0]));
    assign w_seg1      = (r_lzs && (r_active[7:4] == 4'h0)) ? '0
                                                           : SEVEN_SEG_WIDTH'(hex_to_seg(r_active[7:4]));

    assign w_unused_wdata = &{1'b0, bus.S_AXI_WDATA[31:8]};

    // A DATA write on the boundary edge wins over the pending clear.
    always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shadow  <= 8'h00;
            r_active  <= 8'h00;
            r_pending <= 1'b0;
            r_enable  <= 1'b0;
            r_lzs     <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_active <= w_next_active;
            end
            if (w_wr_data) begin
                r_shadow  <= bus.S_AXI_WDATA[7:0];
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_enable <= bus.S_AXI_WDATA[0];
                r_lzs    <= bus.S_AXI_WDATA[1];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_seg        <= '0;
            r_cat        <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (!r_enable) begin
                r_state <= IDLE;
                r_timer <= '0;
                r_seg   <= '0;
                r_cat   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state      <= SHOW0;
                        r_timer      <= '0;
                        r_seg        <= w_seg0_next;
                        r_cat        <= 1'b0;
                        r_frame_tick <= 1'b1;
                    end
                    SHOW0: begin
                        if (r_timer == c_SHOW_LAST) begin
                            r_state <= GAP0;
                            r_timer <= '0;
                            r_seg   <= '0;
                            r_cat   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                            r_seg   <= w_seg0;
                            r_cat   <= 1'b0;
                        end
                    end
                    GAP0: begin
                        if (r_timer == c_GAP_LAST) begin
                            r_state <= SHOW1;
                            r_timer <= '0;
                            r_seg   <= w_seg1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                            r_seg   <= '0;
                        end
                        r_cat <= 1'b1;
                    end
                    SHOW1: begin
                        if (r_timer == c_SHOW_LAST) begin
                            r_state <= GAP1;
                            r_timer <= '0;
                            r_seg   <= '0;
                            r_cat   <= 1'b0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                            r_seg   <= w_seg1;
                            r_cat   <= 1'b1;
                        end
                    end
                    GAP1: begin
                        if (r_timer == c_GAP_LAST) begin
                            r_state      <= SHOW0;
                            r_timer      <= '0;
                            r_seg        <= w_seg0_next;
                            r_frame_tick <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                            r_seg   <= '0;
                        end
                        r_cat <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_seg   <= '0;
                        r_cat   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.SEG            = r_seg;
    assign bus.CAT            = r_cat;
    assign bus.frame_tick     = r_frame_tick;
    assign bus.update_pending = r_pending;

endmodule
`default_nettype wire
